// File: rtl/fp_norm_ctrl_if.sv
// Handshake and counter-side signal bundle for the FP normalization controller.
interface fp_norm_ctrl_if;
    logic        start;
    logic [7:0]  exp_in;
    logic [24:0] mant_in;
    logic [7:0]  exp_out;
    logic        ld_exp;
    logic [7:0]  parin_exp;
    logic        cen_up_exp;
    logic        cen_down_exp;
    logic        busy;
    logic        done;
    logic [22:0] mant_out;
    logic        ovf;
    logic        unf;
    logic        zero;

    modport master (
        output start, exp_in, mant_in, exp_out,
        input  ld_exp, parin_exp, cen_up_exp, cen_down_exp,
        input  busy, done, mant_out, ovf, unf, zero
    );

    modport slave (
        input  start, exp_in, mant_in, exp_out,
        output ld_exp, parin_exp, cen_up_exp, cen_down_exp,
        output busy, done, mant_out, ovf, unf, zero
    );
endinterface

// File: rtl/fp_norm_ctrl.sv
// Sequential mantissa normalizer driving an external exponent up/down counter.
// One shift and at most one counter enable per cycle; start/done handshake.
module fp_norm_ctrl (
    input  logic          clk,
    input  logic          rst,
    fp_norm_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [24:0] r_m;
    logic [24:0] w_m_nxt;
    logic [22:0] r_mant;
    logic [22:0] w_mant_nxt;
    logic        r_ovf;
    logic        r_unf;
    logic        r_zero;
    logic        w_ovf_nxt;
    logic        w_unf_nxt;
    logic        w_zero_nxt;
    logic        w_ld;
    logic        w_up;
    logic        w_down;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_mant  <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_m     <= w_m_nxt;
            r_mant  <= w_mant_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_mant_nxt  = r_mant;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_zero_nxt  = r_zero;
        w_ld        = 1'b0;
        w_up        = 1'b0;
        w_down      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ld = bus.start & rst;
                if (bus.start) begin
                    w_m_nxt     = bus.mant_in;
                    w_mant_nxt  = '0;
                    w_ovf_nxt   = 1'b0;
                    w_unf_nxt   = 1'b0;
                    w_zero_nxt  = 1'b0;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_DONE;
                if (r_m == '0) begin
                    w_zero_nxt = 1'b1;
                    w_mant_nxt = '0;
                end else if (r_m[24]) begin
                    if (bus.exp_out == 8'hFE) begin
                        w_up       = 1'b1;
                        w_ovf_nxt  = 1'b1;
                        w_mant_nxt = '0;
                    end else if (bus.exp_out == 8'hFF) begin
                        w_ovf_nxt  = 1'b1;
                        w_mant_nxt = '0;
                    end else begin
                        // carry: shift right and capture the result on the same edge
                        w_m_nxt    = r_m >> 1;
                        w_up       = 1'b1;
                        w_mant_nxt = r_m[23:1];
                    end
                end else if (r_m[23]) begin
                    w_mant_nxt = r_m[22:0];
                end else if (bus.exp_out <= 8'h01) begin
                    w_unf_nxt  = 1'b1;
                    w_mant_nxt = r_m[22:0];
                end else begin
                    w_m_nxt     = r_m << 1;
                    w_down      = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.ld_exp       = w_ld;
    assign bus.parin_exp    = bus.exp_in;
    assign bus.cen_up_exp   = w_up;
    assign bus.cen_down_exp = w_down;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = (r_state == S_DONE);
    assign bus.mant_out     = r_mant;
    assign bus.ovf          = r_ovf;
    assign bus.unf          = r_unf;
    assign bus.zero         = r_zero;
endmodule

// File: tb/tb_fp_norm_ctrl.sv
// Bench for fp_norm_ctrl: exponent counter model, result model, per-cycle checker.
module tb_fp_norm_ctrl;
    typedef struct {
        logic [7:0]  e;
        logic [22:0] m;
        logic        ovf;
        logic        unf;
        logic        zero;
        int          ups;
        int          downs;
        int          lat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] cnt = 8'h00;
    int checks = 0;
    int errors = 0;
    int n = 0;
    int ups = 0;
    int downs = 0;
    bit active = 1'b0;
    bit finished = 1'b0;
    res_t exp_r;

    fp_norm_ctrl_if bus();

    fp_norm_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // external exponent counter with single-cycle update, not reset
    always @(posedge clk) begin
        if (bus.ld_exp)
            cnt <= bus.parin_exp;
        else if (bus.cen_up_exp)
            cnt <= cnt + 8'd1;
        else if (bus.cen_down_exp)
            cnt <= cnt - 8'd1;
    end
    assign bus.exp_out = cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic res_t model(input logic [7:0] e, input logic [24:0] m);
        res_t r;
        int p;
        int k;
        int avail;
        logic [24:0] s;
        r.e = e; r.m = '0; r.ovf = 0; r.unf = 0; r.zero = 0;
        r.ups = 0; r.downs = 0; r.lat = 2;
        if (m == '0) begin
            r.zero = 1;
        end else if (m[24]) begin
            r.ovf = (e >= 8'hFE);
            if (e != 8'hFF) begin
                r.ups = 1;
                r.e = e + 8'd1;
            end
            if (!r.ovf) begin
                s = m >> 1;
                r.m = s[22:0];
            end
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++)
                if (m[i]) p = i;
            k = 23 - p;
            avail = (e > 8'd1) ? int'(e) - 1 : 0;
            if (k > avail) begin
                r.unf = 1;
                k = avail;
            end
            s = m << k;
            r.m = s[22:0];
            r.e = e - 8'(k);
            r.downs = k;
            r.lat = 2 + k;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (active) begin
            n = n + 1;
            chk("onehot_en", 32'($onehot0({bus.ld_exp, bus.cen_up_exp,
                bus.cen_down_exp})), 1);
            if (bus.cen_up_exp) ups++;
            if (bus.cen_down_exp) downs++;
            chk("busy", 32'(bus.busy), 1);
            chk("done", 32'(bus.done), 32'(n == exp_r.lat));
            if (n == exp_r.lat) begin
                chk("exp_out", 32'(bus.exp_out), 32'(exp_r.e));
                chk("mant_out", 32'(bus.mant_out), 32'(exp_r.m));
                chk("ovf", 32'(bus.ovf), 32'(exp_r.ovf));
                chk("unf", 32'(bus.unf), 32'(exp_r.unf));
                chk("zero", 32'(bus.zero), 32'(exp_r.zero));
                chk("ups", 32'(ups), 32'(exp_r.ups));
                chk("downs", 32'(downs), 32'(exp_r.downs));
                active = 0;
                finished = 1;
            end
        end
    end

    task automatic run(input logic [7:0] e, input logic [24:0] m,
                       input logic [7:0] le, input logic [22:0] lm,
                       input logic [2:0] lf, input bit poke);
        @(negedge clk);
        bus.exp_in = e;
        bus.mant_in = m;
        bus.start = 1'b1;
        #1;
        chk("ld_exp", 32'(bus.ld_exp), 1);
        chk("parin_exp", 32'(bus.parin_exp), 32'(e));
        exp_r = model(e, m);
        n = 0; ups = 0; downs = 0; finished = 0;
        @(posedge clk);
        active = 1;
        @(negedge clk);
        bus.start = 1'b0;
        if (poke) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.mant_in = '0;
            bus.exp_in = 8'h10;
        end
        for (int i = 0; i < 40 && !finished; i++)
            @(negedge clk);
        bus.start = 1'b0;
        if (!finished) begin
            chk("timeout", 0, 1);
            active = 0;
        end
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_done", 32'(bus.done), 0);
        chk("lit_exp", 32'(bus.exp_out), 32'(le));
        chk("lit_mant", 32'(bus.mant_out), 32'(lm));
        chk("lit_flags", 32'({bus.ovf, bus.unf, bus.zero}), 32'(lf));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.exp_in = 8'h00;
        bus.mant_in = '0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_mant", 32'(bus.mant_out), 0);
        chk("rst_flags", 32'({bus.ovf, bus.unf, bus.zero}), 0);
        chk("rst_en", 32'({bus.ld_exp, bus.cen_up_exp, bus.cen_down_exp}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run(8'h80, 25'h0C00000, 8'h80, 23'h400000, 3'b000, 0);
        run(8'h80, 25'h1800001, 8'h81, 23'h400000, 3'b000, 0);
        run(8'h80, 25'h0100000, 8'h7D, 23'h000000, 3'b000, 1);
        run(8'hFE, 25'h1000000, 8'hFF, 23'h000000, 3'b100, 0);
        run(8'h02, 25'h0200000, 8'h01, 23'h400000, 3'b010, 0);
        run(8'h55, 25'h0000000, 8'h55, 23'h000000, 3'b001, 0);
        run(8'hFF, 25'h1000000, 8'hFF, 23'h000000, 3'b100, 0);
        run(8'h01, 25'h0400000, 8'h01, 23'h400000, 3'b010, 0);
        run(8'h80, 25'h0000001, 8'h69, 23'h000000, 3'b000, 0);
        run(8'h03, 25'h0000010, 8'h01, 23'h000040, 3'b010, 0);

        // abort a long shift loop with reset while start is held high
        @(negedge clk);
        bus.exp_in = 8'h80;
        bus.mant_in = 25'h0000001;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 1);
        rst = 1'b0;
        bus.start = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_en", 32'({bus.ld_exp, bus.cen_up_exp, bus.cen_down_exp}), 0);
        chk("arst_outs", 32'({bus.done, bus.ovf, bus.unf, bus.zero}), 0);
        chk("arst_mant", 32'(bus.mant_out), 0);
        chk("arst_parin", 32'(bus.parin_exp), 32'h80);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_nodone", 32'(bus.done), 0);
        end
        bus.start = 1'b0;
        rst = 1'b1;

        run(8'h80, 25'h0C00000, 8'h80, 23'h400000, 3'b000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_norm_ctrl.md
# fp_norm_ctrl

Sequential normalization controller for the floating-point adder. It sits directly upstream of the exponent up/down counter. It captures the raw 25-bit mantissa sum and the pre-normalization exponent, then loads the counter. It shifts the mantissa one bit per cycle while pulsing the counter's increment/decrement enables, and returns a normalized 23-bit fraction with overflow/underflow/zero flags under a start/done handshake.

## Interface
- No parameters; widths fixed (IEEE-754 single: 8-bit exponent, 23-bit fraction).
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- start  in  1  request; sampled only in IDLE
- exp_in  in  8  pre-normalization exponent
- mant_in  in  25  raw sum: bit24 carry, bit23 hidden bit, bits22:0 fraction
- exp_out  in  8  current value returned from the exponent counter
- ld_exp  out  1  counter load enable
- parin_exp  out  8  counter parallel-load value
- cen_up_exp  out  1  counter increment enable
- cen_down_exp  out  1  counter decrement enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- mant_out  out  23  normalized fraction (hidden bit dropped)
- ovf, unf, zero  out  1 each  result flags; held until next accepted start

## Operation
- States: IDLE, CHECK, DONE.
- IDLE:
  - parin_exp = exp_in combinationally; ld_exp = start.
  - On start, latch mant_in into a 25-bit register m, clear all flags, go to CHECK.
- CHECK: exactly one action per cycle, evaluated on m and exp_out with this priority:
  1. m == 0: zero=1, mant_out=0, no counter enable, go to DONE.
  2. m[24]=1, exp_out == 8'hFE: cen_up_exp=1 (counter reaches 8'hFF), ovf=1, mant_out=0, go to DONE.
  3. m[24]=1, exp_out == 8'hFF: ovf=1, mant_out=0, no enable, go to DONE.
  4. m[24]=1, other exp_out: m <= m>>1 (logical; bit0 discarded, no rounding), cen_up_exp=1, go to DONE.
  5. m[23]=1: mant_out=m[22:0], go to DONE.
  6. Otherwise, exp_out <= 8'h01: unf=1, mant_out=m[22:0] unshifted, no enable, go to DONE.
  7. Otherwise: m <= m<<1, cen_down_exp=1, stay in CHECK.
- After rule 4 the shifted mantissa is latched into mant_out on the same edge.
- Each enable is asserted for exactly one cycle, together with its mantissa shift.
- Only one of ld_exp, cen_up_exp, cen_down_exp is high in any cycle.
- DONE: done=1 for one cycle, then go to IDLE unconditionally. start is ignored in DONE.
- start while busy is ignored and has no effect on m or the flags.
- mant_out and all flags are registered and hold after DONE until the next start is accepted. On that start they clear.

## Timing
- Reset: state IDLE, m=0, mant_out=0, busy=0, done=0, ovf=unf=zero=0. While rst=0, all enables are 0: ld_exp=0 and, in IDLE, parin_exp follows exp_in.
- Reset asserted mid-operation aborts immediately. No done pulse is produced, and the counter's partial value is left as is.
- start sampled at edge E0 gives: counter loaded at E0, CHECK during cycle E0..E1.
- Latency from the start edge to done high:
  - already normalized, carry, overflow, zero, or immediate underflow: 2 cycles;
  - k left shifts: 2+k cycles;
  - worst case (m = 25'h0000001, large exponent): 25 cycles.
- The exp_out read in CHECK reflects every enable issued on prior edges; the counter has single-cycle update.
- At done, exp_out holds the final normalized exponent.

## Test plan
- Already normalized: exp_in=8'h80, mant_in=25'h0C00000 -> no up/down pulses, done at cycle 2, mant_out=23'h400000, exp_out=8'h80, flags 0.
- Carry: exp_in=8'h80, mant_in=25'h1800001 -> one cen_up_exp pulse, done at cycle 2, exp_out=8'h81, mant_out=23'h400000.
- Left shift: exp_in=8'h80, mant_in=25'h0100000 -> exactly 3 cen_down_exp pulses, done at cycle 5, exp_out=8'h7D, mant_out=23'h0.
- Boundaries:
  - exp_in=8'hFE, mant_in=25'h1000000 -> ovf=1, exp_out=8'hFF, mant_out=0.
  - exp_in=8'h02, mant_in=25'h0200000 -> one decrement, then unf=1 with exp_out=8'h01, mant_out=23'h400000.
- Zero and control:
  - mant_in=0 -> zero=1, done at cycle 2, no enables.
  - start re-asserted while busy -> ignored.
  - rst pulled low during the shift loop -> all outputs 0, no done pulse.
  - A new start after reset completes normally.
